// File: rtl/waveform_sample_packer.sv
// Sample packer: decimates a narrow sample stream and packs LANES kept
// samples per output word with aligned trigger OR and lane-0 timestamp.
module waveform_sample_packer #(
  parameter  int SAMPLE_WIDTH    = 32,
  parameter  int LANES           = 4,
  parameter  int DECIM_WIDTH     = 16,
  parameter  int TIMESTAMP_WIDTH = 64,
  localparam int DATA_WIDTH      = SAMPLE_WIDTH * LANES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [DECIM_WIDTH-1:0]     decimFactor,
  input  logic [SAMPLE_WIDTH-1:0]    inSample,
  input  logic                       inValid,
  input  logic [7:0]                 inTriggers,
  input  logic [TIMESTAMP_WIDTH-1:0] timestampIn,
  output logic [DATA_WIDTH-1:0]      data,
  output logic                       valid,
  output logic [7:0]                 triggers,
  output logic [TIMESTAMP_WIDTH-1:0] timestamp,
  output logic [31:0]                wordCount
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [DECIM_WIDTH-1:0]     r_decim_cnt;
  logic [LW-1:0]              r_lane_idx;
  logic [DATA_WIDTH-1:0]      r_word_buf;
  logic [TIMESTAMP_WIDTH-1:0] r_pend_ts;
  logic [7:0]                 r_acc;
  logic [DATA_WIDTH-1:0]      r_data;
  logic                       r_valid;
  logic [7:0]                 r_triggers;
  logic [TIMESTAMP_WIDTH-1:0] r_timestamp;
  logic [31:0]                r_word_count;

  logic                       w_keep;
  logic                       w_lane0;
  logic                       w_last;
  logic [DECIM_WIDTH-1:0]     w_reload;
  logic [DATA_WIDTH-1:0]      w_word;
  logic [TIMESTAMP_WIDTH-1:0] w_ts;

  assign w_keep   = enable && inValid && (r_decim_cnt == '0);
  assign w_lane0  = (r_lane_idx == '0);
  assign w_last   = w_keep && (r_lane_idx == LW'(LANES - 1));
  assign w_reload = (decimFactor == '0) ? '0
                  : decimFactor - DECIM_WIDTH'(1);
  // With LANES=1 the lane-0 stamp is the current cycle's timestamp
  assign w_ts     = w_lane0 ? timestampIn : r_pend_ts;

  // Merge the incoming sample into the partial word at its lane
  always_comb begin
    w_word = r_word_buf;
    for (int i = 0; i < LANES; i++) begin
      if (r_lane_idx == LW'(i)) begin
        w_word[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = inSample;
      end
    end
  end

  // Decimation counter: reload on keep, count down on skipped samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_decim_cnt <= '0;
    end else if (!enable) begin
      r_decim_cnt <= '0;
    end else if (inValid) begin
      if (r_decim_cnt == '0) begin
        r_decim_cnt <= w_reload;
      end else begin
        r_decim_cnt <= r_decim_cnt - DECIM_WIDTH'(1);
      end
    end
  end

  // Lane index, partial word assembly and pending lane-0 timestamp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_idx <= '0;
      r_word_buf <= '0;
      r_pend_ts  <= '0;
    end else if (!enable) begin
      r_lane_idx <= '0;
    end else if (w_keep) begin
      r_word_buf <= w_word;
      if (w_lane0) begin
        r_pend_ts <= timestampIn;
      end
      if (w_last) begin
        r_lane_idx <= '0;
      end else begin
        r_lane_idx <= r_lane_idx + LW'(1);
      end
    end
  end

  // Trigger accumulator: OR every enabled cycle, restart after a word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (!enable || w_last) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_acc | inTriggers;
    end
  end

  // Output word registers, updated once per completed word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_triggers   <= '0;
      r_timestamp  <= '0;
      r_word_count <= '0;
    end else begin
      r_valid <= w_last;
      if (w_last) begin
        r_data       <= w_word;
        r_triggers   <= r_acc | inTriggers;
        r_timestamp  <= w_ts;
        r_word_count <= r_word_count + 32'd1;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign triggers  = r_triggers;
  assign timestamp = r_timestamp;
  assign wordCount = r_word_count;

endmodule
